istate_ctrl: RTL

ISTATE_CTRL -- requirements
Module: istate_ctrl

---
 rtl/istate_ctrl_pkg.sv | 40 ++++
 rtl/istate_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/istate_ctrl_pkg.sv
// Shared encodings and the access-permission rule for the internal-state controller.
package istate_ctrl_pkg;

  localparam int ADDR_W      = 6;
  localparam int NUM_IS_REGS = 4;
  localparam int PL_W        = 4;
  localparam logic [PL_W-1:0]   PL_KERNEL   = '0;
  localparam logic [ADDR_W-1:0] IS_ADDR_LIM = ADDR_W'(NUM_IS_REGS);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SETPL = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Returns 1 when the request may proceed; 0 means it is rejected with a fault.
  // SETPL from a non-kernel level may only demote (raise the PL number).
  function automatic logic op_permitted(input op_e               op,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [PL_W-1:0]   new_pl,
                                        input logic [PL_W-1:0]   cur_pl);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_READ:  ok = (addr < IS_ADDR_LIM);
      OP_WRITE: ok = (addr < IS_ADDR_LIM) && (cur_pl == PL_KERNEL);
      OP_SETPL: ok = (cur_pl == PL_KERNEL) || (new_pl >= cur_pl);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/istate_ctrl.sv
// Privilege-checked access controller for the internal-state register file:
// accepts one request, classifies it for one cycle, then holds a response.
module istate_ctrl
  import istate_ctrl_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [5:0]        req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output logic              is_wr_en,
  output logic [5:0]        is_wr_addr,
  output logic [DATA_W-1:0] is_wr_data,
  output logic [5:0]        is_rd_addr,
  input  logic [DATA_W-1:0] is_rd_data,
  output logic              is_pl_en,
  output logic [3:0]        is_pl_data,
  input  logic [3:0]        is_pl_in,
  output logic [7:0]        fault_cnt
);

  state_e              state_q;
  op_e                 op_q;
  logic [5:0]          addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                rsp_valid_q;
  logic                rsp_fault_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [7:0]          fault_cnt_q;
  logic [7:0]          fault_cnt_d;

  logic                in_exec;
  logic                permit;
  logic                wr_go;
  logic                pl_go;
  logic                rd_go;
  logic [DATA_W-1:0]   rd_result;

  // Strobes are decoded from the EXEC state so a reset drops them immediately.
  assign in_exec   = (state_q == ST_EXEC);
  assign permit    = op_permitted(op_q, addr_q, data_q[PL_W-1:0], is_pl_in);
  assign rd_go     = in_exec && permit && (op_q == OP_READ);
  assign wr_go     = in_exec && permit && (op_q == OP_WRITE) && (addr_q != '0);
  assign pl_go     = in_exec && permit && (op_q == OP_SETPL);
  assign rd_result = (rd_go && (addr_q != '0)) ? is_rd_data : '0;

  assign fault_cnt_d = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_fault  = rsp_fault_q;
  assign rsp_data   = rsp_data_q;
  assign fault_cnt  = fault_cnt_q;

  assign is_wr_en   = wr_go;
  assign is_wr_addr = wr_go ? addr_q : '0;
  assign is_wr_data = wr_go ? data_q : '0;
  assign is_pl_en   = pl_go;
  assign is_pl_data = pl_go ? data_q[PL_W-1:0] : '0;
  assign is_rd_addr = rd_go ? addr_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_data_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= op_e'(req_op);
            addr_q  <= req_addr;
            data_q  <= req_data;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= !permit;
          rsp_data_q  <= rd_result;
          if (!permit) begin
            fault_cnt_q <= fault_cnt_d;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_data_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
